vga_timing_gen: RTL

Parametrised VGA timing generator: successor to the fixed 640x480 controller, between the pixel clock domain and the frame-buffer/renderer. Timing comes from parameters, with programmable sync polarity, a pixel clock-enable for clocks faster than the pixel rate, and defined coordinates outside the active area. It adds line/frame strobes and a frame counter. A configurable delay line aligns sync and blanking with a renderer pipeline of known latency.

---
 rtl/vga_timing_pkg.sv | 52 +++++
 rtl/vga_timing_gen_if.sv | 25 ++
 rtl/vga_timing_gen_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA timing presets and the shared stage-flag layout
package vga_timing_pkg;

  // 640x480@60, 25.175 MHz pixel clock
  localparam int VGA_H_VIDEO  = 640;
  localparam int VGA_H_FPORCH = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BPORCH = 48;
  localparam int VGA_V_VIDEO  = 480;
  localparam int VGA_V_FPORCH = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BPORCH = 33;

  // 800x600@60, 40 MHz pixel clock
  localparam int SVGA_H_VIDEO  = 800;
  localparam int SVGA_H_FPORCH = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BPORCH = 88;
  localparam int SVGA_V_VIDEO  = 600;
  localparam int SVGA_V_FPORCH = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BPORCH = 23;

  // Tiny 8x6-slot frame for fast simulation
  localparam int TEST_H_VIDEO  = 4;
  localparam int TEST_H_FPORCH = 1;
  localparam int TEST_H_SYNC   = 2;
  localparam int TEST_H_BPORCH = 1;
  localparam int TEST_V_VIDEO  = 3;
  localparam int TEST_V_FPORCH = 1;
  localparam int TEST_V_SYNC   = 1;
  localparam int TEST_V_BPORCH = 1;

  // Sync flags are kept active-high internally so cleared stages read as inactive
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic inside_video;
    logic line_start;
    logic frame_start;
  } vga_flags_t;

  function automatic int axis_total(input int video, input int fporch,
                                    input int sync, input int bporch);
    return video + fporch + sync + bporch;
  endfunction

  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - video timing bundle from the generator to the renderer
interface vga_timing_gen_if #(
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int FRAME_WIDTH = 8
);
  logic                   h_sync;
  logic                   v_sync;
  logic                   inside_video;
  logic [X_WIDTH-1:0]     x_position;
  logic [Y_WIDTH-1:0]     y_position;
  logic                   line_start;
  logic                   frame_start;
  logic [FRAME_WIDTH-1:0] frame_count;

  modport master (
    output h_sync, v_sync, inside_video, x_position, y_position,
           line_start, frame_start, frame_count
  );

  modport slave (
    input h_sync, v_sync, inside_video, x_position, y_position,
          line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_delay_line.sv
// rtl/vga_timing_gen_delay_line.sv - enable-gated shift register, wire when DEPTH is 0
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = &{1'b0, clock, reset_n, enable};
      assign data_o    = data_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (enable) begin
          stage_q[0] <= data_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign data_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync/blank/coordinate generator with aligned delay
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIDEO     = VGA_H_VIDEO,
  parameter int H_FPORCH    = VGA_H_FPORCH,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BPORCH    = VGA_H_BPORCH,
  parameter int V_VIDEO     = VGA_V_VIDEO,
  parameter int V_FPORCH    = VGA_V_FPORCH,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BPORCH    = VGA_V_BPORCH,
  parameter bit H_POL       = 1'b0,
  parameter bit V_POL       = 1'b0,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int FRAME_WIDTH = 8,
  parameter int PIPE_DELAY  = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pixel_enable,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = axis_total(H_VIDEO, H_FPORCH, H_SYNC, H_BPORCH);
  localparam int V_TOTAL = axis_total(V_VIDEO, V_FPORCH, V_SYNC, V_BPORCH);
  localparam int H_ACT   = H_SYNC + H_BPORCH;
  localparam int V_ACT   = V_SYNC + V_BPORCH;
  localparam int HC_W    = cnt_width(H_TOTAL);
  localparam int VC_W    = cnt_width(V_TOTAL);
  localparam int FLAGS_W = $bits(vga_flags_t);
  localparam int STAGE_W = FLAGS_W + X_WIDTH + Y_WIDTH;

  logic [HC_W-1:0]        h_cnt_q, h_cnt_d;
  logic [VC_W-1:0]        v_cnt_q, v_cnt_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   h_wrap, v_wrap;

  always_comb begin
    h_wrap  = (h_cnt_q == HC_W'(H_TOTAL - 1));
    v_wrap  = (v_cnt_q == VC_W'(V_TOTAL - 1));
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    frame_d = frame_q;
    if (pixel_enable) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + HC_W'(1);
      if (h_wrap) begin
        v_cnt_d = v_wrap ? '0 : v_cnt_q + VC_W'(1);
        if (v_wrap) frame_d = frame_q + FRAME_WIDTH'(1);
      end
    end
  end

  logic [31:0]        h_ext, v_ext;
  logic               h_act, v_act;
  vga_flags_t         flags_d;
  logic [X_WIDTH-1:0] x_d;
  logic [Y_WIDTH-1:0] y_d;

  always_comb begin
    h_ext = 32'(h_cnt_q);
    v_ext = 32'(v_cnt_q);
    h_act = (h_ext >= 32'(H_ACT)) && (h_ext < 32'(H_ACT + H_VIDEO));
    v_act = (v_ext >= 32'(V_ACT)) && (v_ext < 32'(V_ACT + V_VIDEO));
    flags_d.h_sync       = (h_ext < 32'(H_SYNC));
    flags_d.v_sync       = (v_ext < 32'(V_SYNC));
    flags_d.inside_video = h_act && v_act;
    flags_d.line_start   = (h_cnt_q == '0);
    flags_d.frame_start  = (h_cnt_q == '0) && (v_cnt_q == '0);
    // Coordinates are zeroed in blanking so the renderer never sees stale positions
    x_d = flags_d.inside_video ? X_WIDTH'(h_ext - 32'(H_ACT)) : '0;
    y_d = flags_d.inside_video ? Y_WIDTH'(v_ext - 32'(V_ACT)) : '0;
  end

  logic [STAGE_W-1:0] stage0_q, stage0_d, out_stage;
  logic               pe_q;

  assign stage0_d = {flags_d, x_d, y_d};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      frame_q  <= '0;
      stage0_q <= '0;
      pe_q     <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      frame_q <= frame_d;
      // Every stage advances on the same enable, so this marks the clock the output stage loaded
      pe_q    <= pixel_enable;
      if (pixel_enable) stage0_q <= stage0_d;
    end
  end

  vga_delay_line #(
    .WIDTH (STAGE_W),
    .DEPTH (PIPE_DELAY)
  ) u_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (pixel_enable),
    .data_i  (stage0_q),
    .data_o  (out_stage)
  );

  vga_flags_t out_flags;
  assign out_flags = out_stage[STAGE_W-1 -: FLAGS_W];

  assign vid.h_sync       = out_flags.h_sync ^ ~H_POL;
  assign vid.v_sync       = out_flags.v_sync ^ ~V_POL;
  assign vid.inside_video = out_flags.inside_video;
  assign vid.x_position   = out_stage[X_WIDTH+Y_WIDTH-1:Y_WIDTH];
  assign vid.y_position   = out_stage[Y_WIDTH-1:0];
  assign vid.line_start   = out_flags.line_start & pe_q;
  assign vid.frame_start  = out_flags.frame_start & pe_q;
  assign vid.frame_count  = frame_q;

endmodule
